// File: rtl/mem_stage.sv
// Memory stage of the 16-bit 5-stage pipeline: word-addressed data memory, load/store, MEM/WB register.
// Optional MEM_BOUNDS_CHECK_EN: flags and suppresses accesses whose upper address bits are non-zero.
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] pipeline_reg_in,
    input  logic        stall,
    output logic [36:0] pipeline_reg_out,
    output logic [2:0]  mem_op_dest,
    output logic        mem_wb_en,
    output logic [15:0] store_count,
    output logic        mem_addr_err
);

    logic [15:0]       alu_result_s;
    logic              mem_write_en_s;
    logic [15:0]       mem_write_data_s;
    logic              wb_result_mux_s;
    logic [ADDR_W-1:0] addr_s;
    logic [15:0]       raw_read_s;
    logic [15:0]       load_data_s;
    logic              oob_s;
    logic              store_en_s;

    logic [15:0] mem_r [DEPTH];
    logic [36:0] out_r;
    logic [15:0] count_r;

    assign alu_result_s     = pipeline_reg_in[37:22];
    assign mem_write_en_s   = pipeline_reg_in[21];
    assign mem_write_data_s = pipeline_reg_in[20:5];
    assign wb_result_mux_s  = pipeline_reg_in[0];
    assign addr_s           = alu_result_s[ADDR_W-1:0];
    assign raw_read_s       = mem_r[addr_s];

    // Hazard unit sees the destination with zero latency, even in stall/reset
    assign mem_op_dest = pipeline_reg_in[3:1];
    assign mem_wb_en   = pipeline_reg_in[4];

    // Out-of-range detection, load data selection and store qualification
    always_comb begin
        oob_s       = 1'b0;
        load_data_s = raw_read_s;
`ifdef MEM_BOUNDS_CHECK_EN
        if (((alu_result_s >> ADDR_W) != 16'd0) && (mem_write_en_s || wb_result_mux_s) && !stall) begin
            oob_s       = 1'b1;
            load_data_s = 16'h0000;
        end else begin
            oob_s       = 1'b0;
            load_data_s = raw_read_s;
        end
`endif
        store_en_s = mem_write_en_s && !stall && !rst && !oob_s;
    end

    // Data memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (store_en_s) begin
            mem_r[addr_s] <= mem_write_data_s;
        end
    end

    // MEM/WB register and committed-store counter; load data is read-before-write
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r   <= 37'd0;
            count_r <= 16'd0;
        end else if (!stall) begin
            out_r <= {load_data_s, alu_result_s, pipeline_reg_in[4:0]};
            if (store_en_s) begin
                count_r <= count_r + 16'd1;
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic err_r;

    // Sticky out-of-range flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (oob_s) begin
            err_r <= 1'b1;
        end
    end

    assign mem_addr_err = err_r;
`else
    assign mem_addr_err = 1'b0;
`endif

    assign pipeline_reg_out = out_r;
    assign store_count      = count_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations follow the MEM_BOUNDS_CHECK_EN setting.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] pipeline_reg_in;
    logic        stall;
    logic [36:0] pipeline_reg_out;
    logic [2:0]  mem_op_dest;
    logic        mem_wb_en;
    logic [15:0] store_count;
    logic        mem_addr_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;
    logic [36:0] held;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_reg_in  (pipeline_reg_in),
        .stall            (stall),
        .pipeline_reg_out (pipeline_reg_out),
        .mem_op_dest      (mem_op_dest),
        .mem_wb_en        (mem_wb_en),
        .store_count      (store_count),
        .mem_addr_err     (mem_addr_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic s, input logic [15:0] alu, input logic we,
                         input logic [15:0] wd, input logic wb, input logic [2:0] dest, input logic mux);
        rst             = r;
        stall           = s;
        pipeline_reg_in = {alu, we, wd, wb, dest, mux};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset for two cycles
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        check("reset_out", pipeline_reg_out, 37'd0);
        check("reset_cnt", {21'd0, store_count}, 37'd0);
        check("reset_err", {36'd0, mem_addr_err}, 37'd0);
        exp_cnt = 16'd0;

        // Store 0xBEEF at 0x0012
        drive(1'b0, 1'b0, 16'h0012, 1'b1, 16'hBEEF, 1'b0, 3'd0, 1'b0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("store_cnt", {21'd0, store_count}, {21'd0, exp_cnt});

        // Load 0x0012, wb_en=1 dest=5 mux=1
        drive(1'b0, 1'b0, 16'h0012, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b1);
        tick();
        check("load_full", pipeline_reg_out, {16'hBEEF, 16'h0012, 5'b11011});
        check("load_cnt", {21'd0, store_count}, {21'd0, exp_cnt});
        held = {16'hBEEF, 16'h0012, 5'b11011};

        // Stalled store must not commit and output must hold
        drive(1'b0, 1'b1, 16'h0012, 1'b1, 16'h1234, 1'b0, 3'd2, 1'b0);
        #1;
        check("stall_dest_comb", {34'd0, mem_op_dest}, {34'd0, 3'd2});
        tick();
        tick();
        check("stall_hold_out", pipeline_reg_out, held);
        check("stall_hold_cnt", {21'd0, store_count}, {21'd0, exp_cnt});

        drive(1'b0, 1'b0, 16'h0012, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b1);
        tick();
        check("post_stall_load", {21'd0, pipeline_reg_out[36:21]}, {21'd0, 16'hBEEF});

        // ALU pass-through
        drive(1'b0, 1'b0, 16'h7F00, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0);
        #1;
        check("pass_dest_comb", {34'd0, mem_op_dest}, {34'd0, 3'd3});
        check("pass_wben_comb", {36'd0, mem_wb_en}, {36'd0, 1'b1});
        tick();
        check("pass_alu", {21'd0, pipeline_reg_out[20:5]}, {21'd0, 16'h7F00});
        check("pass_ctl", {32'd0, pipeline_reg_out[4:0]}, {32'd0, 5'b10110});

        // Address above DEPTH: wraps by default, rejected with the bounds check
        drive(1'b0, 1'b0, 16'h0105, 1'b1, 16'hAAAA, 1'b0, 3'd0, 1'b0);
        tick();
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_cnt", {21'd0, store_count}, {21'd0, exp_cnt});
        check("oob_err", {36'd0, mem_addr_err}, {36'd0, 1'b1});
        drive(1'b0, 1'b0, 16'h0105, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b1);
        tick();
        check("oob_load", {21'd0, pipeline_reg_out[36:21]}, 37'd0);
        check("oob_err_sticky", {36'd0, mem_addr_err}, {36'd0, 1'b1});
`else
        exp_cnt = exp_cnt + 16'd1;
        check("wrap_cnt", {21'd0, store_count}, {21'd0, exp_cnt});
        check("wrap_err", {36'd0, mem_addr_err}, 37'd0);
        drive(1'b0, 1'b0, 16'h0005, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b1);
        tick();
        check("wrap_load", {21'd0, pipeline_reg_out[36:21]}, {21'd0, 16'hAAAA});
`endif

        // Store over 0x0012: registered read data is the old word
        drive(1'b0, 1'b0, 16'h0012, 1'b1, 16'h5555, 1'b0, 3'd0, 1'b0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("rbw_old", {21'd0, pipeline_reg_out[36:21]}, {21'd0, 16'hBEEF});
        check("rbw_cnt", {21'd0, store_count}, {21'd0, exp_cnt});
        drive(1'b0, 1'b0, 16'h0012, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b1);
        tick();
        check("rbw_new", {21'd0, pipeline_reg_out[36:21]}, {21'd0, 16'h5555});

        // Reset during a store, with stall also high
        drive(1'b1, 1'b1, 16'h0012, 1'b1, 16'h9999, 1'b1, 3'd6, 1'b1);
        #1;
        check("rst_dest_comb", {34'd0, mem_op_dest}, {34'd0, 3'd6});
        tick();
        check("rst_mid_out", pipeline_reg_out, 37'd0);
        check("rst_mid_cnt", {21'd0, store_count}, 37'd0);
        check("rst_mid_err", {36'd0, mem_addr_err}, 37'd0);
        drive(1'b0, 1'b0, 16'h0012, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b1);
        tick();
        check("rst_no_commit", {21'd0, pipeline_reg_out[36:21]}, {21'd0, 16'h5555});

        // 65536 stores wrap the counter back to zero
        for (int i = 0; i < 65536; i++) begin
            drive(1'b0, 1'b0, {8'h00, i[7:0]}, 1'b1, i[15:0], 1'b0, 3'd0, 1'b0);
            tick();
            if (i == 65534) begin
                check("cnt_ffff", {21'd0, store_count}, {21'd0, 16'hFFFF});
            end
        end
        check("cnt_wrap", {21'd0, store_count}, 37'd0);
        drive(1'b0, 1'b0, 16'h00FF, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1);
        tick();
        check("last_store", {21'd0, pipeline_reg_out[36:21]}, {21'd0, 16'hFFFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
